mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between NUM_CORES processor cores in the multi-core matrix engine.
- Round-robin arbitration with a req/ack handshake per core. One transaction is in flight at a time.
- Sits between the cores' load/store units and the synchronous data memory that the top-level loader fills.
- Exposes a 2-bit state output for top-level debug, in the same style as the main block's state port.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 16, memory word width; matches the com_data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- core_req  in  NUM_CORES  per-core request; held high until the matching ack.
- core_we  in  NUM_CORES  per-core write enable (1 = store, 0 = load).
- core_addr  in  NUM_CORES*ADDR_WIDTH  packed addresses; core i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- core_wdata  in  NUM_CORES*DATA_WIDTH  packed write data, same packing as core_addr.
- core_ack  out  NUM_CORES  one-hot, one-cycle completion pulse.
- core_rdata  out  DATA_WIDTH  load data broadcast to all cores; valid while core_ack is high.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after the mem_en edge.
- state  out  2  FSM state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE.

Behaviour:
- All outputs are registered. On rst: state=IDLE, core_ack=0, core_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, grant=0, last_grant=NUM_CORES-1 (so core 0 wins first).
- IDLE:
  - If core_req != 0, pick the first requesting core searching upward from last_grant+1, wrapping modulo NUM_CORES.
  - Latch grant. Register mem_en=1, mem_we=core_we[grant], and that core's addr/wdata. Go to ISSUE.
  - Otherwise stay in IDLE with mem_en=0.
- ISSUE: memory samples its inputs at the end of this cycle. Next edge: mem_en=0, mem_we=0, go to WAIT.
- WAIT:
  - mem_rdata is valid.
  - For a load, register core_rdata=mem_rdata. For a store, core_rdata keeps its previous value.
  - Register core_ack=one-hot(grant), set last_grant=grant, go to DONE.
- DONE:
  - core_ack is high for exactly this cycle. Next edge: core_ack=0, go to IDLE.
  - No arbitration takes place in DONE.
- Latency: request sampled at edge E0, ack high in the cycle after E2 (3 cycles). Back-to-back throughput without the option is 1 access per 4 cycles.
- The core deasserts core_req on the edge where it samples ack. The arbiter therefore never re-grants a completed request.
- Once in ISSUE, a transaction is committed. Dropping core_req mid-transaction does not cancel it; the ack still pulses.
- addr/we/wdata are captured only in IDLE. Later changes to the core's inputs are ignored.
- Simultaneous requests: exactly one is granted, in round-robin order. A core waits at most NUM_CORES-1 transactions.
- A single requester is re-granted repeatedly with no gap beyond the FSM latency.
- rst asserted in any state aborts the transaction: no ack is produced and all registers return to reset values at that edge.
- If NUM_CORES is not a power of two, the wrap arithmetic must never select a core index >= NUM_CORES.

Optional Feature:
- Macro ARB_BACK_TO_BACK_EN.
- Defined: in DONE, if any core other than grant has core_req high, arbitrate among them (the granted core is masked, since its req is still high) and go directly to ISSUE, loading the mem_* registers. Throughput becomes 1 access per 3 cycles. If no other core requests, go to IDLE.
- Undefined: DONE always returns to IDLE (1 access per 4 cycles).

Decomposition:
- State encodings (IDLE/ISSUE/WAIT/DONE), default widths and NUM_CORES go in the shared definitions.v include.
- One sub-module: rr_picker, purely combinational.
  - Inputs: request vector, last_grant, mask vector.
  - Outputs: grant index and a valid bit.
  - Reused in IDLE and, under ARB_BACK_TO_BACK_EN, in DONE.

Test Plan:
- Reset then a single load: core 2 loads addr 0x0010 with memory holding 0x1234 -> mem_en high one cycle with addr 0x0010, core_ack=4'b0100 in the 3rd cycle after the request, core_rdata=0x1234.
- All four cores request at once -> grants in order 0,1,2,3, each ack one cycle, no duplicate grants. Then core 0 requests again -> granted next.
- Core 1 stores 0xBEEF to 0x0003, then core 3 loads 0x0003 -> core 3 receives 0xBEEF. core_rdata stays unchanged during the store ack.
- Core 0 drops req while state=WAIT -> ack still pulses for core 0 and the FSM returns to IDLE cleanly.
- rst asserted during ISSUE with cores 0 and 1 requesting -> no ack, state=0 next cycle, core 0 granted first after reset.
- ARB_BACK_TO_BACK_EN defined, cores 0 and 1 requesting continuously -> state goes DONE->ISSUE directly, acks spaced 3 cycles apart, grants alternate 0,1,0,1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  localparam int DEF_NUM_CORES  = 4;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;

  // Encoding is visible on the debug state port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: first set bit of (req & ~mask) searching upward from last_grant+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld=0 when no unmasked request is present.
// Ports: req/mask (N bits), last_grant (index) in; grant (index), vld out.
module mem_port_arbiter_rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int N  = DEF_NUM_CORES,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          vld
);

  logic [N-1:0] cand;
  assign cand = req & ~mask;

  always_comb begin
    int c;
    c     = 0;
    grant = '0;
    vld   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      // last_grant < N always, so one conditional subtract keeps c in 0..N-1
      // even when N is not a power of two.
      c = int'(last_grant) + k;
      if (c >= N) c = c - N;
      if (!vld && cand[c[IW-1:0]]) begin
        vld   = 1'b1;
        grant = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous data-memory port between NUM_CORES cores, round-robin, one access in flight.
// Latency: req sampled at E0 -> mem_en after E0 -> core_ack pulse after E2 (3 cycles).
// Backpressure: core holds core_req until ack; 1 access / 4 cycles, 1 / 3 with ARB_BACK_TO_BACK_EN.
// Ports: core_req/we/addr/wdata in, core_ack/core_rdata out (cores side);
//        mem_en/we/addr/wdata out, mem_rdata in (memory side); state out (debug).
// Build option: define ARB_BACK_TO_BACK_EN to re-arbitrate directly from DONE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CORES-1:0]            core_req,
  input  logic [NUM_CORES-1:0]            core_we,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata,
  output logic [NUM_CORES-1:0]            core_ack,
  output logic [DATA_WIDTH-1:0]           core_rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic [1:0]                      state
);

  localparam int IW = $clog2(NUM_CORES);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_CORES - 1);
  localparam logic [NUM_CORES-1:0] ONE = NUM_CORES'(1);

  arb_state_t             st_q, st_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic                   op_we_q, op_we_d;    // mem_we drops after ISSUE, so keep the op type
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

  logic [NUM_CORES-1:0]   pick_mask;
  logic [IW-1:0]          pick_idx;
  logic                   pick_vld;
  logic                   load_issue;

`ifdef ARB_BACK_TO_BACK_EN
  // In DONE the finishing core still holds its req; keep it out of the pick.
  assign pick_mask = (st_q == ST_DONE) ? (ONE << grant_q) : '0;
`else
  assign pick_mask = '0;
`endif

  mem_port_arbiter_rr_picker #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_picker (
    .req        (core_req),
    .mask       (pick_mask),
    .last_grant (last_q),
    .grant      (pick_idx),
    .vld        (pick_vld)
  );

  always_comb begin
    st_d        = st_q;
    grant_d     = grant_q;
    last_d      = last_q;
    op_we_d     = op_we_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_issue  = 1'b0;

    case (st_q)
      ST_IDLE:  load_issue = pick_vld;
      ST_ISSUE: st_d = ST_WAIT;
      ST_WAIT: begin
        if (!op_we_q) rdata_d = mem_rdata;
        ack_d  = ONE << grant_q;
        last_d = grant_q;
        st_d   = ST_DONE;
      end
      ST_DONE: begin
        st_d = ST_IDLE;
`ifdef ARB_BACK_TO_BACK_EN
        load_issue = pick_vld;
`endif
      end
      default: st_d = ST_IDLE;
    endcase

    // Command capture happens only here; later input changes are ignored.
    if (load_issue) begin
      st_d        = ST_ISSUE;
      grant_d     = pick_idx;
      op_we_d     = core_we[pick_idx];
      mem_en_d    = 1'b1;
      mem_we_d    = core_we[pick_idx];
      mem_addr_d  = core_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata_d = core_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= LAST_RST;
      op_we_q     <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      st_q        <= st_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      op_we_q     <= op_we_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign core_ack   = ack_q;
  assign core_rdata = rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign state      = st_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int N = 4, AW = 16, DW = 16;
`ifdef ARB_BACK_TO_BACK_EN
  localparam int B2B = 1;
`else
  localparam int B2B = 0;
`endif
  localparam int GAP  = B2B ? 3 : 4;
  localparam int MAXE = 4096;
  localparam int RCYC = 2500;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    core_req, core_we, core_ack;
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [DW-1:0]   core_rdata, mem_wdata, mem_rdata;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [1:0]      state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state(state)
  );

  // Synchronous memory (256 words, low address byte) with a bench preload port.
  logic [DW-1:0] mem [0:255];
  logic          pl_en;
  logic [7:0]    pl_addr;
  logic [DW-1:0] pl_dat;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  int n_chk = 0, n_err = 0, edge_cnt = 0;
  logic [DW-1:0] ref_mem [0:255];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic set_core(input int i, input logic rq, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_req[i] = rq;
    core_we[i]  = we;
    core_addr[i*AW +: AW]  = a;
    core_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    core_req = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a[7:0]; pl_dat = d;
    tick;
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic wait_ack(output logic [N-1:0] got, output int lat);
    got = '0; lat = 0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (core_ack != 0) begin got = core_ack; lat = k; break; end
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++)
      if (r[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  typedef struct {
    int          core;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [3:0]  exp_ack;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t tv [7];

  // Random-phase reference: per-edge input snapshots and expected outputs.
  logic [N-1:0]    s_req [MAXE], s_we [MAXE];
  logic [N*AW-1:0] s_addr [MAXE];
  logic [N*DW-1:0] s_wd [MAXE];
  logic [N-1:0]    e_ack [MAXE];
  logic [1:0]      e_st [MAXE];
  logic            e_men [MAXE], e_we [MAXE], a_we [MAXE];
  logic [AW-1:0]   e_addr [MAXE], a_addr [MAXE];
  logic [DW-1:0]   e_wd [MAXE], a_wd [MAXE];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] got, drop, reraise;
    int lat, prev, idx, nd;
    int order [$];
    int arb_e, last;
    logic arb_mask, chk_next;
    logic [DW-1:0] exp_rd;

    tv[0] = '{2, 1'b0, 16'h0010, 16'h0000, 4'b0100, 16'h1234};
    tv[1] = '{1, 1'b1, 16'h0003, 16'hBEEF, 4'b0010, 16'h1234};
    tv[2] = '{3, 1'b0, 16'h0003, 16'h0000, 4'b1000, 16'hBEEF};
    tv[3] = '{0, 1'b1, 16'h0020, 16'h5A5A, 4'b0001, 16'hBEEF};
    tv[4] = '{0, 1'b0, 16'h0020, 16'h0000, 4'b0001, 16'h5A5A};
    tv[5] = '{1, 1'b0, 16'h0044, 16'h0000, 4'b0010, 16'hE1E1};
    tv[6] = '{2, 1'b0, 16'h0003, 16'h0000, 4'b0100, 16'hBEEF};

    rst = 1'b1; core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
    tick; tick;
    chk("rst_state", state, 0);
    chk("rst_ack", core_ack, 0);
    chk("rst_rdata", core_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    for (int a = 0; a < 256; a++) preload(a, 16'((a * 16'h0101) ^ 16'hA5A5));
    preload(16'h10, 16'h1234);
    rst = 1'b0;

    // Single-core transactions from the table.
    for (int v = 0; v < 7; v++) begin
      lat = 0;
      set_core(tv[v].core, 1'b1, tv[v].we, tv[v].addr, tv[v].wd);
      for (int k = 1; k <= 10 && lat == 0; k++) begin
        tick;
        if (k == 1) begin
          chk("vec_mem_en", mem_en, 1);
          chk("vec_mem_we", mem_we, tv[v].we);
          chk("vec_mem_addr", mem_addr, tv[v].addr);
          if (tv[v].we) chk("vec_mem_wdata", mem_wdata, tv[v].wd);
        end
        if (core_ack != 0) lat = k;
      end
      chk("vec_latency", lat, 3);
      chk("vec_ack", core_ack, tv[v].exp_ack);
      chk("vec_rdata", core_rdata, tv[v].exp_rd);
      tick;
      core_req[tv[v].core] = 1'b0;
      chk("vec_ack_pulse", core_ack, 0);
      tick; tick;
    end

    // All four request together: order 0,1,2,3, fixed spacing.
    do_reset;
    for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, 16'(16'h0040 + i), 16'h0);
    drop = '0; prev = -1;
    for (int k = 0; k < 40 && order.size() < 4; k++) begin
      tick;
      for (int i = 0; i < N; i++) if (drop[i]) begin core_req[i] = 1'b0; drop[i] = 1'b0; end
      if (core_ack != 0) begin
        chk("seqA_onehot", $countones(core_ack), 1);
        if (prev >= 0) chk("seqA_gap", edge_cnt - prev, GAP);
        prev = edge_cnt;
        for (int i = 0; i < N; i++) if (core_ack[i]) idx = i;
        order.push_back(idx);
        drop[idx] = 1'b1;
      end
    end
    chk("seqA_count", order.size(), 4);
    for (int j = 0; j < order.size(); j++) chk("seqA_order", order[j], j);
    tick; core_req = '0; tick; tick;
    set_core(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    wait_ack(got, lat);
    chk("seqA_regrant0", got, 4'b0001);
    tick; core_req[0] = 1'b0; tick; tick;

    // Core 0 drops req while in WAIT: ack still pulses, clean return to IDLE.
    set_core(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    for (int k = 0; k < 10; k++) begin tick; if (state == 2) break; end
    chk("seqB_reach_wait", state, 2);
    core_req[0] = 1'b0;
    tick;
    chk("seqB_ack", core_ack, 4'b0001);
    chk("seqB_rdata", core_rdata, 16'h1234);
    tick;
    chk("seqB_idle", state, 0);
    got = '0;
    for (int k = 0; k < 6; k++) begin tick; got = got | core_ack; end
    chk("seqB_no_regrant", got, 0);

    // Reset during ISSUE aborts; core 0 wins first afterwards.
    set_core(0, 1'b1, 1'b0, 16'h0003, 16'h0);
    set_core(1, 1'b1, 1'b0, 16'h0044, 16'h0);
    for (int k = 0; k < 10; k++) begin tick; if (state == 1) break; end
    chk("seqC_issue", state, 1);
    rst = 1'b1;
    tick;
    chk("seqC_rst_state", state, 0);
    chk("seqC_rst_ack", core_ack, 0);
    chk("seqC_rst_mem_en", mem_en, 0);
    rst = 1'b0;
    wait_ack(got, lat);
    chk("seqC_first_ack", got, 4'b0001);
    chk("seqC_first_lat", lat, 3);
    chk("seqC_rdata0", core_rdata, 16'hBEEF);
    tick; core_req[0] = 1'b0;
    wait_ack(got, lat);
    chk("seqC_second_ack", got, 4'b0010);
    chk("seqC_rdata1", core_rdata, 16'hE1E1);
    tick; core_req = '0; tick; tick;

    // Cores 0 and 1 requesting continuously: alternate grants, DONE exit state.
    do_reset;
    set_core(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    set_core(1, 1'b1, 1'b0, 16'h0003, 16'h0);
    drop = '0; reraise = '0; prev = -1; nd = 0; chk_next = 1'b0;
    for (int k = 0; k < 60 && nd < 6; k++) begin
      tick;
      if (chk_next) begin chk("seqD_after_done", state, B2B ? 1 : 0); chk_next = 1'b0; end
      for (int i = 0; i < N; i++) begin
        if (reraise[i]) begin core_req[i] = 1'b1; reraise[i] = 1'b0; end
        if (drop[i]) begin core_req[i] = 1'b0; drop[i] = 1'b0; reraise[i] = 1'b1; end
      end
      if (core_ack != 0) begin
        chk("seqD_ack", core_ack, (nd % 2 == 0) ? 4'b0001 : 4'b0010);
        if (prev >= 0) chk("seqD_gap", edge_cnt - prev, GAP);
        prev = edge_cnt;
        for (int i = 0; i < N; i++) if (core_ack[i]) drop[i] = 1'b1;
        chk_next = 1'b1;
        nd++;
      end
    end
    chk("seqD_count", nd, 6);
    core_req = '0;

    // Randomized traffic against a transaction-level reference.
    for (int e = 0; e < MAXE; e++) begin
      e_ack[e] = '0; e_st[e] = 2'd0; e_men[e] = 1'b0;
    end
    do_reset;
    edge_cnt = 0;
    arb_e = 1; arb_mask = 1'b0; last = N - 1; exp_rd = '0; drop = '0;
    for (int c = 0; c < RCYC; c++) begin
      int e, g;
      logic [N-1:0] cand;
      s_req[edge_cnt + 1]  = core_req;
      s_we[edge_cnt + 1]   = core_we;
      s_addr[edge_cnt + 1] = core_addr;
      s_wd[edge_cnt + 1]   = core_wdata;
      tick;
      e = edge_cnt;
      if (e == arb_e) begin
        cand = s_req[e];
        if (arb_mask) cand[last] = 1'b0;
        if (cand != 0) begin
          g = rr_pick(cand, last);
          last = g;
          e_st[e] = 2'd1; e_st[e + 1] = 2'd2; e_st[e + 2] = 2'd3;
          e_men[e]  = 1'b1;
          e_we[e]   = s_we[e][g];
          e_addr[e] = s_addr[e][g*AW +: AW];
          e_wd[e]   = s_wd[e][g*DW +: DW];
          e_ack[e + 2]  = N'(1) << g;
          a_we[e + 2]   = e_we[e];
          a_addr[e + 2] = e_addr[e];
          a_wd[e + 2]   = e_wd[e];
          arb_e = e + GAP;
          arb_mask = (B2B == 1);
        end else begin
          arb_e = e + 1;
          arb_mask = 1'b0;
        end
      end
      if (e_ack[e] != 0) begin
        if (a_we[e]) ref_mem[a_addr[e][7:0]] = a_wd[e];
        else exp_rd = ref_mem[a_addr[e][7:0]];
      end
      chk("rnd_ack", core_ack, e_ack[e]);
      chk("rnd_state", state, e_st[e]);
      chk("rnd_mem_en", mem_en, e_men[e]);
      if (e_men[e]) begin
        chk("rnd_mem_we", mem_we, e_we[e]);
        chk("rnd_mem_addr", mem_addr, e_addr[e]);
        if (e_we[e]) chk("rnd_mem_wdata", mem_wdata, e_wd[e]);
      end
      chk("rnd_rdata", core_rdata, exp_rd);
      for (int i = 0; i < N; i++) begin
        if (drop[i]) begin core_req[i] = 1'b0; drop[i] = 1'b0; end
        else if (e_ack[e][i]) drop[i] = 1'b1;
        else if (!core_req[i] && $urandom_range(3) == 0) core_req[i] = 1'b1;
        if ($urandom_range(3) == 0) begin
          core_we[i] = 1'($urandom_range(1));
          core_addr[i*AW +: AW]  = 16'($urandom);
          core_wdata[i*DW +: DW] = 16'($urandom);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
